csa64_result_fifo: RTL
======================

# csa64_result_fifo

Registered result buffer that sits directly downstream of the 64-bit carry-select adder (CSA64bit). It captures each valid `sum`/`c_out` pair the adder produces into a DEPTH-entry FIFO with a valid/ready handshake on both sides. Each entry is tagged with a zero flag. The block also keeps a saturating carry-out counter and a sticky drop-error flag for software visibility.

## Interface
- `WIDTH`, 64: data width; must match the adder sum width.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CW`, 16: width of the carry-out counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  the adder result on `in_sum`/`in_c_out` is valid this cycle.
- `in_ready`  out  1  the FIFO can accept a push.
- `in_sum`  in  WIDTH  adder `sum`.
- `in_c_out`  in  1  adder `c_out`.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  the consumer accepts the head entry.
- `out_sum`  out  WIDTH  head entry sum.
- `out_c_out`  out  1  head entry carry.
- `out_zero`  out  1  head entry sum == 0.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `carry_cnt`  out  CW  number of accepted pushes with `in_c_out`=1; saturates.
- `drop_err`  out  1  sticky flag: a push was attempted while the FIFO was full.
- `clr_stats`  in  1  synchronous clear of `carry_cnt` and `drop_err`.

## Operation
- **Push:** occurs when `in_valid && in_ready`. Writes {`in_sum`, `in_c_out`, `in_sum==0`} at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- **Pop:** occurs when `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- **Readiness:** `in_ready = (count != DEPTH)`. It is derived only from registered `count`; there is no pass-through when full, even if a pop happens in the same cycle.
- **Head presentation:** `out_valid = (count != 0)`. The FIFO is show-ahead: `out_sum`, `out_c_out` and `out_zero` present `mem[rd_ptr]` whenever `out_valid`=1.
- **Simultaneous push and pop:** legal whenever `count` is in 1..DEPTH-1. `count` is unchanged and both pointers advance.
- **Push and pop when empty:** a push at `count`=0 cannot pop the same cycle, because `out_valid`=0.
- **Pop when full:** a pop at `count`=DEPTH frees a slot; `in_ready` rises the next cycle.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, the head outputs hold stable. Pushes never alter the head entry.
- **`carry_cnt`:** increments by 1 on each accepted push with `in_c_out`=1, and holds at 2^CW-1.
- **`clr_stats` with a carry push in the same cycle:** `carry_cnt` becomes 1. Events in a clear cycle are counted.
- **`drop_err`:** set when `in_valid && !in_ready`. The dropped data is discarded and no state other than `drop_err` changes.
- **`clr_stats` with a drop in the same cycle:** `drop_err` stays 1 (set wins).
- **Reset** (`rst_n`=0, asynchronous, may occur mid-operation):
  - Pointers, `count`, `carry_cnt`, `drop_err` and every memory entry go to 0.
  - Consequently `out_valid`=0, `out_sum`=0, `out_c_out`=0, and `out_zero`=1 (it reflects the zeroed head).
  - `in_ready`=1.
  - In-flight entries are lost. The first push after `rst_n` deasserts behaves exactly as from empty.

## Timing
- **Latency:** a push accepted at edge N into an empty FIFO gives `out_valid`=1 with that data after edge N, i.e. one cycle.
- **Throughput:** one push and one pop per cycle, sustained.
- **Status update timing:** `count`, `in_ready` and `out_valid` update one cycle after the handshake edge.
- **`carry_cnt`/`drop_err` timing:** both update at the same edge as the triggering event.
- **Combinational paths:** none from any input to any output. `in_ready` and `out_valid` depend only on registers.
- **Upstream path:** `in_sum`/`in_c_out` come straight from the combinational adder and must meet setup within the same cycle as `in_valid`.

## Test plan
1. **Single push.** After reset, push `in_sum`=64'h0000_0000_0000_000C, `in_c_out`=0 → next cycle `out_valid`=1, `out_sum`=0x0C, `out_zero`=0, `count`=1. Pop with `out_ready`=1 → `count`=0, `out_valid`=0.
2. **Fill with backpressure and drop.** Hold `out_ready`=0 and push 4 entries (1,2,3,4) → `count`=4, `in_ready`=0. A 5th push (value 5) → `drop_err`=1 and `count` stays 4. Draining gives 1,2,3,4 in order; 5 is never seen.
3. **Sustained throughput.** Push every cycle with `out_ready`=1 for 20 cycles, values 0..19 → `count` stays 1 after the first cycle, output order matches input, and pointers wrap correctly.
4. **Carry counting, saturation and clear.** Push `in_sum`=0, `in_c_out`=1 → `out_zero`=1, `out_c_out`=1, `carry_cnt`=1. Force 2^CW carry pushes → `carry_cnt`=16'hFFFF holds. Assert `clr_stats` together with a carry push → `carry_cnt`=1 and `drop_err` clears. Assert `clr_stats` together with a drop → `drop_err` stays 1.
5. **Full with simultaneous pop.** At `count`=4, assert `out_ready`=1 and `in_valid`=1 in the same cycle → the pop occurs, the push is dropped (`drop_err`=1), `count`=3 and `in_ready`=1 the next cycle.
6. **Asynchronous reset mid-operation.** With `count`=3, pulse `rst_n` low between clock edges → outputs go to their reset values immediately (`out_valid`=0, `count`=0, `carry_cnt`=0). After release, push 7 → `out_sum`=7 one cycle later.

Source files
------------

// File: rtl/csa64_result_fifo.sv
// csa64_result_fifo: show-ahead result buffer behind the 64-bit carry-select adder.
// Holds sum/c_out pairs, tags the head with a zero flag, and keeps carry/drop statistics.
module csa64_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_sum,
    input  logic                       in_c_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_c_out,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CW-1:0]              carry_cnt,
    output logic                       drop_err,
    input  logic                       clr_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic [WIDTH-1:0] mem_sum [DEPTH];
    logic             mem_c   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;
    logic             carry_push;

    // Status and head come only from registers, so no input reaches an output.
    assign in_ready   = (count != FULL);
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign drop       = in_valid && !in_ready;
    assign carry_push = push && in_c_out;

    // The zero tag is derived from the stored head sum so a cleared entry reads as zero.
    assign out_sum   = mem_sum[rd_ptr];
    assign out_c_out = mem_c[rd_ptr];
    assign out_zero  = (mem_sum[rd_ptr] == '0);

    // Storage: written only on an accepted push, so the head is never disturbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_sum[i] <= '0;
                mem_c[i]   <= 1'b0;
            end
        end else if (push) begin
            mem_sum[wr_ptr] <= in_sum;
            mem_c[wr_ptr]   <= in_c_out;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy tracks push/pop; both together leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating carry counter; an event in a clear cycle is still counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (clr_stats) begin
            carry_cnt <= carry_push ? CW'(1) : '0;
        end else if (carry_push && carry_cnt != CMAX) begin
            carry_cnt <= carry_cnt + CW'(1);
        end
    end

    // Sticky drop flag; a drop in a clear cycle wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end else if (clr_stats) begin
            drop_err <= 1'b0;
        end
    end

endmodule
